// File: rtl/mem_access_unit_pkg.sv
// Shared constants and decode helpers for the MEM-stage load/store unit:
// op codes, exception causes, FSM state type and lane/alignment decode.
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;
    localparam logic [3:0] MEM_OP_LL   = 4'd9;
    localparam logic [3:0] MEM_OP_SC   = 4'd10;

    localparam logic [4:0] EXC_CAUSE_NONE = 5'h1f;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mau_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_LL};
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SC};
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:            return off[0];
            MEM_OP_LW, MEM_OP_SW, MEM_OP_LL, MEM_OP_SC: return off != 2'b00;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Lane enables are driven for loads too so the slave knows which bytes matter.
    function automatic logic [3:0] op_lanes(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB:            return 4'b0001 << off;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:            return off[1] ? 4'b1100 : 4'b0011;
            MEM_OP_LW, MEM_OP_SW, MEM_OP_LL, MEM_OP_SC: return 4'b1111;
            default:                                    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] op_wdata(input logic [3:0] op, input logic [31:0] data);
        case (op)
            MEM_OP_SB: return {4{data[7:0]}};
            MEM_OP_SH: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword from a bus word and sign- or zero-extends it.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            MEM_OP_LB:            load_value = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU:           load_value = {24'd0, byte_sel};
            MEM_OP_LH:            load_value = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU:           load_value = {16'd0, half_sel};
            MEM_OP_LW, MEM_OP_LL: load_value = rdata;
            default:              load_value = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-beat req/ack bus transactions, pipeline
// stall, load alignment, address-error detection and the LL bit for LL/SC.
//
// state | meaning
// IDLE  | no transaction; decode op, flag exceptions, accept and stall
// BUSY  | request on the bus, waiting for ack
// DONE  | result valid, stall released, pipeline advances
// DRAIN | flushed while busy; hold request until ack, discard result
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  i_MEM_mem_op,
    input  logic [31:0] i_MEM_addr,
    input  logic [31:0] i_MEM_store_data,
    input  logic [4:0]  i_MEM_except_cause,
    input  logic        i_flush,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [3:0]  o_dbus_wstrb,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic [4:0]  o_except_cause,
    output logic [31:0] o_badvaddr,
    output logic        o_LL_bit
);

    mau_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] load_data_q, load_data_d;
    logic        ll_q, ll_d;

    logic        op_load, op_store, op_valid;
    logic        exc_in, addr_err, sc_fail, accept;
    logic [31:0] aligned_value;

    mem_load_align u_load_align (
        .op         (op_q),
        .off        (addr_q[1:0]),
        .rdata      (i_dbus_rdata),
        .load_value (aligned_value)
    );

    always_comb begin
        op_load  = op_is_load(i_MEM_mem_op);
        op_store = op_is_store(i_MEM_mem_op);
        op_valid = op_load | op_store;
        exc_in   = i_MEM_except_cause != EXC_CAUSE_NONE;
        addr_err = op_valid & op_misaligned(i_MEM_mem_op, i_MEM_addr[1:0]);
        sc_fail  = (i_MEM_mem_op == MEM_OP_SC) & ~ll_q;
        accept   = (state_q == ST_IDLE) & op_valid & ~exc_in & ~addr_err & ~sc_fail;

        if (exc_in)        o_except_cause = i_MEM_except_cause;
        else if (addr_err) o_except_cause = op_store ? EXC_CAUSE_ADES : EXC_CAUSE_ADEL;
        else               o_except_cause = EXC_CAUSE_NONE;
        o_badvaddr = (!exc_in && addr_err) ? i_MEM_addr : 32'd0;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        we_d        = we_q;
        op_d        = op_q;
        load_data_d = load_data_q;
        ll_d        = ll_q;
        o_stall     = 1'b0;
        o_load_data = load_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && !i_flush) begin
                    o_stall = 1'b1;
                    state_d = ST_BUSY;
                    addr_d  = i_MEM_addr;
                    wdata_d = op_wdata(i_MEM_mem_op, i_MEM_store_data);
                    wstrb_d = op_lanes(i_MEM_mem_op, i_MEM_addr[1:0]);
                    we_d    = op_store;
                    op_d    = i_MEM_mem_op;
                end
                // Any SC consumes the reservation, whether or not it goes to the bus.
                if (i_MEM_mem_op == MEM_OP_SC && !exc_in) ll_d = 1'b0;
                if (sc_fail && !exc_in && !addr_err) begin
                    o_load_data = 32'd0;
                    load_data_d = 32'd0;
                end
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (i_dbus_ack) begin
                    if (i_flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        if (op_q == MEM_OP_SC)     load_data_d = 32'd1;
                        else if (op_is_load(op_q)) load_data_d = aligned_value;
                        if (op_q == MEM_OP_LL)     ll_d = 1'b1;
                    end
                end else if (i_flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                o_stall = 1'b1;
                if (i_dbus_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) ll_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            we_q        <= 1'b0;
            op_q        <= MEM_OP_NONE;
            load_data_q <= 32'd0;
            ll_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            we_q        <= we_d;
            op_q        <= op_d;
            load_data_q <= load_data_d;
            ll_q        <= ll_d;
        end
    end

    assign o_dbus_req   = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
    assign o_dbus_we    = we_q;
    assign o_dbus_wstrb = wstrb_q;
    assign o_dbus_addr  = {addr_q[31:2], 2'b00};
    assign o_dbus_wdata = wdata_q;
    assign o_LL_bit     = ll_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single operations
// plus hand-written flush, LL and reset sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_MEM_mem_op;
    logic [31:0] i_MEM_addr;
    logic [31:0] i_MEM_store_data;
    logic [4:0]  i_MEM_except_cause;
    logic        i_flush;
    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [3:0]  o_dbus_wstrb;
    logic [31:0] o_dbus_addr;
    logic [31:0] o_dbus_wdata;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;
    logic        o_stall;
    logic [31:0] o_load_data;
    logic [4:0]  o_except_cause;
    logic [31:0] o_badvaddr;
    logic        o_LL_bit;

    mem_access_unit dut (
        .clk                (clk),
        .reset              (reset),
        .i_MEM_mem_op       (i_MEM_mem_op),
        .i_MEM_addr         (i_MEM_addr),
        .i_MEM_store_data   (i_MEM_store_data),
        .i_MEM_except_cause (i_MEM_except_cause),
        .i_flush            (i_flush),
        .o_dbus_req         (o_dbus_req),
        .o_dbus_we          (o_dbus_we),
        .o_dbus_wstrb       (o_dbus_wstrb),
        .o_dbus_addr        (o_dbus_addr),
        .o_dbus_wdata       (o_dbus_wdata),
        .i_dbus_ack         (i_dbus_ack),
        .i_dbus_rdata       (i_dbus_rdata),
        .o_stall            (o_stall),
        .o_load_data        (o_load_data),
        .o_except_cause     (o_except_cause),
        .o_badvaddr         (o_badvaddr),
        .o_LL_bit           (o_LL_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  cause;
        int          ack_wait;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_cause;
        logic        chk_badv;
        logic [31:0] exp_badv;
        logic        chk_load;
        logic [31:0] exp_load;
        int          exp_stall;
        logic        exp_ll;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];
    vec_t v_tmp;

    int n_checks = 0;
    int n_fail   = 0;
    int drain_cyc;
    logic drain_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_ld(input logic [3:0] op, input logic [31:0] addr, input int wt,
                                   input logic [31:0] rd, input logic [3:0] strb,
                                   input logic [31:0] baddr, input logic [31:0] ld, input logic ll);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = 32'd0; v.cause = EXC_CAUSE_NONE;
        v.ack_wait = wt; v.rdata = rd;
        v.exp_req = 1'b1; v.exp_we = 1'b0; v.exp_wstrb = strb; v.exp_addr = baddr;
        v.exp_wdata = 32'd0; v.exp_cause = EXC_CAUSE_NONE; v.chk_badv = 1'b0; v.exp_badv = 32'd0;
        v.chk_load = 1'b1; v.exp_load = ld; v.exp_stall = wt + 2; v.exp_ll = ll;
        return v;
    endfunction

    function automatic vec_t mk_st(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input int wt, input logic [3:0] strb,
                                   input logic [31:0] baddr, input logic [31:0] ewd);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd; v.cause = EXC_CAUSE_NONE;
        v.ack_wait = wt; v.rdata = 32'h0BAD_0BAD;
        v.exp_req = 1'b1; v.exp_we = 1'b1; v.exp_wstrb = strb; v.exp_addr = baddr;
        v.exp_wdata = ewd; v.exp_cause = EXC_CAUSE_NONE; v.chk_badv = 1'b0; v.exp_badv = 32'd0;
        v.chk_load = 1'b0; v.exp_load = 32'd0; v.exp_stall = wt + 2; v.exp_ll = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_exc(input logic [3:0] op, input logic [31:0] addr,
                                    input logic [4:0] cin, input logic [4:0] ecause,
                                    input logic chkb, input logic [31:0] badv);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = 32'h5555_AAAA; v.cause = cin;
        v.ack_wait = 0; v.rdata = 32'd0;
        v.exp_req = 1'b0; v.exp_we = 1'b0; v.exp_wstrb = 4'd0; v.exp_addr = 32'd0;
        v.exp_wdata = 32'd0; v.exp_cause = ecause; v.chk_badv = chkb; v.exp_badv = badv;
        v.chk_load = 1'b0; v.exp_load = 32'd0; v.exp_stall = 0; v.exp_ll = 1'b0;
        return v;
    endfunction

    // Presents one op, plays the bus slave, and checks everything the op should produce.
    task automatic run_op(input vec_t v, input string tag);
        int   stall_cnt = 0;
        int   req_cnt = 0;
        logic req_seen = 1'b0;
        logic done = 1'b0;
        logic        s_we = 1'b0;
        logic [3:0]  s_strb = 4'd0;
        logic [31:0] s_addr = 32'd0;
        logic [31:0] s_wdata = 32'd0;
        @(posedge clk); #1;
        i_MEM_mem_op       = v.op;
        i_MEM_addr         = v.addr;
        i_MEM_store_data   = v.wdata;
        i_MEM_except_cause = v.cause;
        i_dbus_ack         = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({tag, " cause"}, {27'd0, o_except_cause}, {27'd0, v.exp_cause});
                if (v.chk_badv) check({tag, " badvaddr"}, o_badvaddr, v.exp_badv);
            end
            if (o_stall) stall_cnt++;
            if (o_dbus_req) begin
                if (!req_seen) begin
                    s_we = o_dbus_we; s_strb = o_dbus_wstrb;
                    s_addr = o_dbus_addr; s_wdata = o_dbus_wdata;
                end
                req_seen = 1'b1;
                req_cnt++;
                i_dbus_ack   = (req_cnt == v.ack_wait + 1);
                i_dbus_rdata = v.rdata;
            end else begin
                i_dbus_ack = 1'b0;
            end
            if (!o_stall) begin
                done = 1'b1;
                break;
            end
        end
        i_dbus_ack = 1'b0;
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        check({tag, " req"}, {31'd0, req_seen}, {31'd0, v.exp_req});
        check({tag, " stall cycles"}, stall_cnt, v.exp_stall);
        if (v.exp_req) begin
            check({tag, " we"}, {31'd0, s_we}, {31'd0, v.exp_we});
            check({tag, " wstrb"}, {28'd0, s_strb}, {28'd0, v.exp_wstrb});
            check({tag, " addr"}, s_addr, v.exp_addr);
            if (v.exp_we) check({tag, " wdata"}, s_wdata, v.exp_wdata);
        end
        if (v.chk_load) check({tag, " load_data"}, o_load_data, v.exp_load);
        check({tag, " ll_bit"}, {31'd0, o_LL_bit}, {31'd0, v.exp_ll});
    endtask

    initial begin
        vecs[0]  = mk_ld(MEM_OP_LB,  32'h1003, 2, 32'h80FF1234, 4'b1000, 32'h1000, 32'hFFFFFF80, 1'b0);
        vecs[1]  = mk_st(MEM_OP_SH,  32'h2002, 32'h0000ABCD, 0, 4'b1100, 32'h2000, 32'hABCDABCD);
        vecs[2]  = mk_exc(MEM_OP_LW, 32'h3001, EXC_CAUSE_NONE, EXC_CAUSE_ADEL, 1'b1, 32'h3001);
        vecs[3]  = mk_exc(MEM_OP_SW, 32'h3002, EXC_CAUSE_NONE, EXC_CAUSE_ADES, 1'b1, 32'h3002);
        vecs[4]  = mk_ld(MEM_OP_LBU, 32'h1002, 1, 32'h80FF1234, 4'b0100, 32'h1000, 32'h000000FF, 1'b0);
        vecs[5]  = mk_ld(MEM_OP_LH,  32'h1002, 0, 32'h80FF1234, 4'b1100, 32'h1000, 32'hFFFF80FF, 1'b0);
        vecs[6]  = mk_ld(MEM_OP_LHU, 32'h1000, 0, 32'h80FF1234, 4'b0011, 32'h1000, 32'h00001234, 1'b0);
        vecs[7]  = mk_ld(MEM_OP_LW,  32'h1004, 3, 32'hDEADBEEF, 4'b1111, 32'h1004, 32'hDEADBEEF, 1'b0);
        vecs[8]  = mk_st(MEM_OP_SB,  32'h6001, 32'h000000A5, 1, 4'b0010, 32'h6000, 32'hA5A5A5A5);
        vecs[9]  = mk_ld(MEM_OP_LL,  32'h4000, 0, 32'h11111111, 4'b1111, 32'h4000, 32'h11111111, 1'b1);
        vecs[10] = mk_st(MEM_OP_SC,  32'h4000, 32'h12345678, 1, 4'b1111, 32'h4000, 32'h12345678);
        vecs[10].chk_load = 1'b1;
        vecs[10].exp_load = 32'd1;
        vecs[11] = mk_exc(MEM_OP_SC, 32'h4000, EXC_CAUSE_NONE, EXC_CAUSE_NONE, 1'b0, 32'd0);
        vecs[11].chk_load = 1'b1;
        vecs[11].exp_load = 32'd0;
        vecs[12] = mk_exc(MEM_OP_LW, 32'h5001, EXC_CAUSE_OV, EXC_CAUSE_OV, 1'b0, 32'd0);
        vecs[13] = mk_exc(MEM_OP_LH, 32'h7001, EXC_CAUSE_NONE, EXC_CAUSE_ADEL, 1'b1, 32'h7001);
        vecs[14] = mk_exc(MEM_OP_SC, 32'h4002, EXC_CAUSE_NONE, EXC_CAUSE_ADES, 1'b1, 32'h4002);
        vecs[15] = mk_exc(4'hC,      32'h1000, EXC_CAUSE_NONE, EXC_CAUSE_NONE, 1'b0, 32'd0);
        vecs[16] = mk_ld(MEM_OP_LB,  32'h1000, 0, 32'h0000007F, 4'b0001, 32'h1000, 32'h0000007F, 1'b0);

        reset              = 1'b1;
        i_MEM_mem_op       = MEM_OP_NONE;
        i_MEM_addr         = 32'd0;
        i_MEM_store_data   = 32'd0;
        i_MEM_except_cause = EXC_CAUSE_NONE;
        i_flush            = 1'b0;
        i_dbus_ack         = 1'b0;
        i_dbus_rdata       = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req",   {31'd0, o_dbus_req}, 32'd0);
        check("reset we",    {31'd0, o_dbus_we}, 32'd0);
        check("reset wstrb", {28'd0, o_dbus_wstrb}, 32'd0);
        check("reset addr",  o_dbus_addr, 32'd0);
        check("reset wdata", o_dbus_wdata, 32'd0);
        check("reset load",  o_load_data, 32'd0);
        check("reset ll",    {31'd0, o_LL_bit}, 32'd0);
        check("reset stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // Flush while BUSY: drain until the late ack, no result, no LL update.
        v_tmp = mk_ld(MEM_OP_LW, 32'h1008, 0, 32'hCAFEF00D, 4'b1111, 32'h1008, 32'hCAFEF00D, 1'b0);
        run_op(v_tmp, "pre-drain");
        @(posedge clk); #1;
        i_MEM_mem_op = MEM_OP_LL; i_MEM_addr = 32'h8000;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk);
        check("busy req", {31'd0, o_dbus_req}, 32'd1);
        check("busy stall", {31'd0, o_stall}, 32'd1);
        @(posedge clk); #1;
        i_flush = 1'b0; i_MEM_mem_op = MEM_OP_NONE;
        drain_cyc = 0; drain_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!o_stall) begin
                drain_done = 1'b1;
                break;
            end
            if (o_dbus_req) drain_cyc++;
            i_dbus_ack   = (drain_cyc == 3);
            i_dbus_rdata = 32'h12345678;
        end
        i_dbus_ack = 1'b0;
        check("drain completed", {31'd0, drain_done}, 32'd1);
        check("drain cycles", drain_cyc, 3);
        check("drain req released", {31'd0, o_dbus_req}, 32'd0);
        check("drain load kept", o_load_data, 32'hCAFEF00D);
        check("drain ll", {31'd0, o_LL_bit}, 32'd0);

        // Flush in IDLE with an acceptable op: nothing issued, no stall.
        @(posedge clk); #1;
        i_MEM_mem_op = MEM_OP_LW; i_MEM_addr = 32'hA000; i_flush = 1'b1;
        @(negedge clk);
        check("idle flush stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
        i_flush = 1'b0; i_MEM_mem_op = MEM_OP_NONE;
        @(negedge clk);
        check("idle flush req", {31'd0, o_dbus_req}, 32'd0);

        // Flush clears a held reservation.
        v_tmp = mk_ld(MEM_OP_LL, 32'h4000, 1, 32'h22222222, 4'b1111, 32'h4000, 32'h22222222, 1'b1);
        run_op(v_tmp, "ll2");
        @(posedge clk); #1;
        i_MEM_mem_op = MEM_OP_NONE; i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(negedge clk);
        check("flush clears ll", {31'd0, o_LL_bit}, 32'd0);

        // Reset during BUSY drops the request on the next edge.
        v_tmp = mk_ld(MEM_OP_LL, 32'h4000, 0, 32'h33333333, 4'b1111, 32'h4000, 32'h33333333, 1'b1);
        run_op(v_tmp, "ll3");
        @(posedge clk); #1;
        i_MEM_mem_op = MEM_OP_LW; i_MEM_addr = 32'h9000;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset req", {31'd0, o_dbus_req}, 32'd1);
        reset = 1'b1; i_MEM_mem_op = MEM_OP_NONE;
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset req",   {31'd0, o_dbus_req}, 32'd0);
        check("midreset stall", {31'd0, o_stall}, 32'd0);
        check("midreset load",  o_load_data, 32'd0);
        check("midreset ll",    {31'd0, o_LL_bit}, 32'd0);
        check("midreset addr",  o_dbus_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit fed by the EXE/MEM pipeline register. It turns the registered memory operation into a single-beat request/acknowledge transaction on the data bus and stalls the pipeline while the transaction is outstanding. It aligns and sign- or zero-extends load data, raises address-error exceptions, and owns the LL bit for LL/SC.

## Interface
- No parameters. Widths are fixed at 32-bit data and address.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_MEM_mem_op` in 4: operation code; encodings defined under Structure.
- `i_MEM_addr` in 32: effective address (ALU result).
- `i_MEM_store_data` in 32: register value to store.
- `i_MEM_except_cause` in 5: exception carried in from earlier stages; `EXC_CAUSE_NONE` means none.
- `i_flush` in 1: pipeline flush from CP0 (exception or eret commit).
- `o_dbus_req` out 1: bus request.
- `o_dbus_we` out 1: write request.
- `o_dbus_wstrb` out 4: byte lane enables.
- `o_dbus_addr` out 32: word-aligned address (`[1:0]`=0).
- `o_dbus_wdata` out 32: write data.
- `i_dbus_ack` in 1: bus acknowledge.
- `i_dbus_rdata` in 32: read data, valid with `i_dbus_ack`.
- `o_stall` out 1: freeze IF..MEM and the EXE/MEM register.
- `o_load_data` out 32: aligned and extended load result (SC: success flag).
- `o_except_cause` out 5: resolved exception cause.
- `o_badvaddr` out 32: faulting address.
- `o_LL_bit` out 1: current LL bit.

## Operation
- Op codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8, LL=9, SC=10. Codes 11-15 are treated as NONE.
- Exception priority is incoming cause, then address error.
  - Incoming cause ≠ NONE: pass it through and make no bus access.
  - Misalignment is address bit 0 set for halfword ops, or `[1:0]`≠0 for word, LL and SC. Misaligned loads and LL raise ADEL (4); misaligned stores and SC raise ADES (5).
  - On an address error, `o_badvaddr` = `i_MEM_addr`, with no bus access and no stall.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0]; byte replicated ×4.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; halfword replicated ×2.
  - SW and SC: wstrb = 4'b1111.
- Loads select the byte/halfword by `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend.
- LL bit:
  - Set when an LL transaction completes.
  - Cleared by `i_flush` and by any SC.
  - SC with LL bit=0 makes no bus access and returns `o_load_data`=0 with no stall.
  - SC with LL bit=1 stores the word and returns 1 on ack.
- FSM states:
  - IDLE: an accepted op (valid, aligned, no exception, not a failing SC) asserts `o_stall` combinationally and latches addr, wdata, wstrb, we and op. Next state is BUSY; with `i_flush`, stay in IDLE.
  - BUSY: `o_dbus_req`=1 and `o_stall`=1; request fields hold stable. On `i_dbus_ack`, capture rdata and go to DONE. `i_flush` without ack goes to DRAIN. `i_flush` with ack goes to IDLE with the data discarded.
  - DONE: `o_stall`=0 and `o_load_data` is valid; the pipeline advances at this edge. Next state is IDLE; the current op is not reissued.
  - DRAIN: `o_dbus_req`=1 and `o_stall`=1 until ack, then IDLE. No LL update and no result.

## Timing
- Reset values: state IDLE, `o_dbus_req`/`o_dbus_we`=0, `o_dbus_wstrb`=0, `o_dbus_addr`/`o_dbus_wdata`=0, `o_load_data`=0, LL bit=0, `o_stall`=0.
- Reset mid-transaction drops the request on the next edge; the bus slave must tolerate an abandoned request.
- Minimum latency: op presented in cycle 0 and ack in cycle 1 gives the result in cycle 2; stall is high in cycles 0-1.
- Each wait cycle before ack adds one stall cycle.
- `o_dbus_req` is driven from registered state only; the request fields are registered.
- Exception and badvaddr outputs are combinational in IDLE and valid in the same cycle the op is presented.

## Structure
- Op-code constants go in a new shared include `MemOp.v`.
- `EXC_CAUSE_NONE`, `EXC_CAUSE_ADEL` (4) and `EXC_CAUSE_ADES` (5) are added to `Exception.v`.
- One combinational sub-module, `mem_load_align`, takes (op, addr[1:0], rdata) and produces the extended load value.

## Test plan
- LB at addr 0x1003, ack after 2 wait cycles with rdata 0x80FF1234 → `o_load_data`=0xFFFFFF80; stall high for 4 cycles (the op cycle, the request cycle and the 2 wait cycles); byte lane 3 selected.
- SH at 0x2002, data 0x0000ABCD, immediate ack → addr 0x2000, wstrb 1100, wdata 0xABCDABCD, `o_dbus_we`=1.
- LW at 0x3001 → ADEL (4), badvaddr 0x3001, no `o_dbus_req`, no stall. SW at 0x3002 → ADES (5).
- LL at 0x4000 (ack), then SC at 0x4000 → store issued, result 1, LL bit 0. A second SC → no request, result 0.
- `i_flush` during BUSY with ack 3 cycles later → DRAIN, stall held until ack, then IDLE; `o_load_data` and the LL bit are unchanged.
- Incoming cause OV with LW at 0x5001 → `o_except_cause`=OV (not ADEL); no bus access.
